// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and stream geometry for imem_loader; CSUM exists only with IMEM_LOADER_CHECKSUM_EN
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;
`endif

endpackage

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - packs accepted bytes LSB-first into 32-bit words, one-cycle word_valid pulse
module imem_loader_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        cnt;
  logic [WORD_W-9:0] sr;

  // the byte arriving now completes the word
  assign last_byte = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && last_byte;
      if (byte_en) begin
        if (last_byte) begin
          word <= {byte_data, sr};
          cnt  <= '0;
        end else begin
          sr  <= {byte_data, sr[WORD_W-9:8]};
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory, holds the core in reset until loaded
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [16:0]       DEPTH_N = 17'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE   = 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CSUM;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  state_t              state, state_nxt;
  logic [7:0]          n_lo;
  logic [ADDR_WIDTH:0] n_words;
  logic [ADDR_WIDTH:0] widx;
  logic [ADDR_WIDTH:0] widx_inc;
  logic [16:0]         hdr_n;
  logic                accepting;
  logic                xfer;
  logic                data_xfer;
  logic                last_byte;
  logic                word_valid;
  logic                done_q;

  assign accepting = (state == HDR_LO) || (state == HDR_HI) || (state == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state == CSUM)
`endif
                     ;

  assign byte_ready = rst && accepting;
  assign xfer       = byte_valid && byte_ready;
  assign data_xfer  = xfer && (state == DATA);
  assign hdr_n      = {1'b0, byte_data, n_lo};
  assign widx_inc   = widx + ONE;

  imem_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (data_xfer),
    .byte_data  (byte_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (imem_wdata)
  );

  assign imem_we = word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xsum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xsum <= '0;
    end else if (xfer && (state != CSUM)) begin
      xsum <= xsum ^ byte_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR_LO;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (xfer) state_nxt = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_n > DEPTH_N) begin
            state_nxt = ERR;
          end else if (hdr_n == '0) begin
            state_nxt = AFTER_PAYLOAD;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: if (data_xfer && last_byte && (widx_inc == n_words)) state_nxt = AFTER_PAYLOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (xfer) state_nxt = (byte_data == xsum) ? DONE : ERR;
`endif
      default: ;
    endcase
  end

  // release lags DONE by one edge so the final write commits first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lo      <= '0;
      n_words   <= '0;
      widx      <= '0;
      imem_addr <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (xfer && (state == HDR_LO)) begin
        n_lo <= byte_data;
      end
      if (xfer && (state == HDR_HI)) begin
        n_words <= hdr_n[ADDR_WIDTH:0];
      end
      if (data_xfer && last_byte) begin
        imem_addr <= widx[ADDR_WIDTH-1:0];
        widx      <= widx_inc;
      end
    end
  end

  assign load_done = done_q;
  assign core_rst  = done_q;
  assign load_err  = (state == ERR);

endmodule
